// File: rtl/ir_bus_command_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ir_bus_command_if: bus-mapped COMMAND/SEND_PACKET front end for the IR tx. |
// | STATUS readback via macro IR_READBACK_EN.   Rev 1.0                        |
// +----------------------------------------------------------------------------+
module ir_bus_command_if #(
  parameter logic [7:0]  BaseAddr    = 8'h90,
  parameter int unsigned SendPeriod  = 5_000_000,
  parameter int unsigned HoldPackets = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_addr,
  input  logic [7:0] bus_data_in,
  input  logic       bus_we,
  input  logic       bus_re,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  output logic [3:0] command,
  output logic       send_packet
);

  typedef enum logic [0:0] {DISABLED = 1'b0, RUNNING = 1'b1} state_t;

  localparam int              WD_W       = (HoldPackets < 1) ? 1 : $clog2(HoldPackets + 1);
  localparam logic [22:0]     LAST_COUNT = 23'(SendPeriod - 1);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(HoldPackets);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(HoldPackets - 1);
  localparam logic [7:0]      CMD_ADDR   = BaseAddr;
  localparam logic [7:0]      CTRL_ADDR  = BaseAddr + 8'd1;

  state_t          state;
  state_t          next_state;
  logic [22:0]     period_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_flag;
  logic            cmd_we;
  logic            ctrl_we;
  logic            one_shot;
  logic            wrap;
  logic            fire;
  logic [3:0]      cmd_clean;

  assign cmd_we   = bus_we && (bus_addr == CMD_ADDR);
  assign ctrl_we  = bus_we && (bus_addr == CTRL_ADDR);
  assign one_shot = ctrl_we && bus_data_in[1];
  assign wrap     = (state == RUNNING) && (period_cnt == LAST_COUNT);

  // Opposing direction bits cancel each other rather than reaching the car.
  assign cmd_clean[1:0] = (bus_data_in[1:0] == 2'b11) ? 2'b00 : bus_data_in[1:0];
  assign cmd_clean[3:2] = (bus_data_in[3:2] == 2'b11) ? 2'b00 : bus_data_in[3:2];

  always_ff @(posedge clk) begin
    if (rst) state <= DISABLED;
    else     state <= next_state;
  end

  // Suppressing on the registered pulse keeps SEND_PACKET from ever going back-to-back.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    if (ctrl_we) next_state = bus_data_in[0] ? RUNNING : DISABLED;
    fire = (wrap || one_shot) && !send_packet;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt  <= '0;
      send_packet <= 1'b0;
    end else begin
      send_packet <= fire;
      if (one_shot || next_state == DISABLED) period_cnt <= '0;
      else if (state == RUNNING)              period_cnt <= wrap ? 23'd0 : period_cnt + 23'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      command <= 4'd0;
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (cmd_we) begin
      command <= cmd_clean;
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (fire && wd_cnt != WD_LIMIT) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) begin
        command <= 4'd0;
        wd_flag <= 1'b1;
      end
    end
  end

`ifdef IR_READBACK_EN
  localparam logic [7:0] STAT_ADDR = BaseAddr + 8'd2;
  logic status_rd;
  logic unused_inputs;

  assign status_rd     = bus_re && (bus_addr == STAT_ADDR);
  assign unused_inputs = ^bus_data_in[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_data_oe  <= 1'b0;
      bus_data_out <= 8'h00;
    end else begin
      bus_data_oe  <= status_rd;
      bus_data_out <= status_rd ? {2'b00, wd_flag, (state == RUNNING), command} : 8'h00;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{bus_data_in[7:4], bus_re};
  assign bus_data_oe   = 1'b0;
  assign bus_data_out  = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ir_bus_command_if.sv
`default_nettype none
// Bench for ir_bus_command_if: directed scenarios then random bus traffic, checked
// every cycle against an event-time reference model.
module tb_ir_bus_command_if;

  localparam int         P     = 10;
  localparam int         H     = 3;
  localparam logic [7:0] BASE  = 8'h90;
  localparam logic [7:0] A_CMD = BASE;
  localparam logic [7:0] A_CTL = BASE + 8'd1;
  localparam logic [7:0] A_STA = BASE + 8'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_addr = 8'h00;
  logic [7:0] bus_data_in = 8'h00;
  logic       bus_we = 1'b0;
  logic       bus_re = 1'b0;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [3:0] command;
  logic       send_packet;

  always #5 clk = ~clk;

  ir_bus_command_if #(.BaseAddr(BASE), .SendPeriod(P), .HoldPackets(H)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data_in(bus_data_in),
    .bus_we(bus_we), .bus_re(bus_re), .bus_data_out(bus_data_out),
    .bus_data_oe(bus_data_oe), .command(command), .send_packet(send_packet)
  );

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;

  // Reference model: periodic pulses are scheduled as absolute edge numbers.
  longint     n      = 0;
  longint     m_due  = -1;
  logic [3:0] m_cmd  = 4'd0;
  bit         m_en   = 1'b0;
  int         m_wd   = 0;
  bit         m_flag = 1'b0;
  bit         m_pulse = 1'b0;
  bit         m_oe   = 1'b0;
  logic [7:0] m_dout = 8'h00;

  function automatic logic [3:0] sanitize(logic [7:0] d);
    logic [3:0] s;
    s = d[3:0];
    if (s[1:0] == 2'b11) s[1:0] = 2'b00;
    if (s[3:2] == 2'b11) s[3:2] = 2'b00;
    return s;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model(bit r, bit we, bit re, logic [7:0] a, logic [7:0] d);
    bit cmd_w, ctl_w, os, rd, pulse;
    n++;
    if (r) begin
      m_due = -1; m_cmd = 4'd0; m_en = 1'b0; m_wd = 0; m_flag = 1'b0;
      m_pulse = 1'b0; m_oe = 1'b0; m_dout = 8'h00;
      return;
    end
    cmd_w = we && (a == A_CMD);
    ctl_w = we && (a == A_CTL);
    os    = ctl_w && d[1];
`ifdef IR_READBACK_EN
    rd = re && (a == A_STA);
`else
    rd = 1'b0;
`endif
    m_oe   = rd;
    m_dout = rd ? {2'b00, m_flag, m_en, m_cmd} : 8'h00;
    pulse  = ((m_en && m_due == n) || os) && !m_pulse;
    if (ctl_w) begin
      if (d[0] && !m_en) m_due = n + P;
      else if (!d[0])    m_due = -1;
      m_en = d[0];
    end
    if (m_due == n)  m_due = n + P;
    if (os && m_en)  m_due = n + P;
    if (cmd_w) begin
      m_cmd = sanitize(d); m_wd = 0; m_flag = 1'b0;
    end else if (pulse && m_wd < H) begin
      m_wd++;
      if (m_wd == H) begin m_cmd = 4'd0; m_flag = 1'b1; end
    end
    m_pulse = pulse;
  endtask

  task automatic step(bit r, bit we, bit re, logic [7:0] a, logic [7:0] d);
    rst = r; bus_we = we; bus_re = re; bus_addr = a; bus_data_in = d;
    @(posedge clk);
    model(r, we, re, a, d);
    #1;
    if (send_packet === 1'b1) pulses++;
    check("command", {4'h0, command}, {4'h0, m_cmd});
    check("send_packet", {7'h0, send_packet}, {7'h0, m_pulse});
    check("data_oe", {7'h0, bus_data_oe}, {7'h0, m_oe});
    check("data_out", bus_data_out, m_dout);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  // Idle until the next edge is a scheduled periodic pulse (bounded).
  task automatic to_pre_pulse();
    int guard;
    guard = 0;
    while (m_due != n + 1 && guard < 4 * P) begin idle(1); guard++; end
    compared++;
    assert (m_due == n + 1) else begin
      mismatched++;
      $error("FAIL pre_pulse_wait: observed due %0d expected %0d", m_due, n + 1);
    end
  endtask

  initial begin
    int p0;
    logic [7:0] a, d;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);

    // Basic command capture and periodic pulses (watchdog trips on 3rd).
    wr(A_CMD, 8'h09);
    wr(A_CTL, 8'h01);
    p0 = pulses;
    idle(3 * P + 2);
    check("periodic_count", 8'(pulses - p0), 8'd3);

    // Sanitising.
    wr(A_CMD, 8'h0F);
    wr(A_CMD, 8'h07);
    wr(A_CMD, 8'hF6);

    // One-shot while disabled, back-to-back one-shots.
    wr(A_CTL, 8'h00);
    p0 = pulses;
    wr(A_CTL, 8'h02);
    idle(2 * P);
    check("oneshot_disabled", 8'(pulses - p0), 8'd1);
    wr(A_CTL, 8'h02);
    wr(A_CTL, 8'h02);
    idle(2);

    // One-shot coinciding with a periodic pulse.
    wr(A_CMD, 8'h0A);
    wr(A_CTL, 8'h01);
    to_pre_pulse();
    wr(A_CTL, 8'h03);
    idle(P + 2);

    // Watchdog then recovery by CMD write.
    wr(A_CTL, 8'h00);
    wr(A_CMD, 8'h08);
    wr(A_CTL, 8'h01);
    idle(3 * P + 3);
    check("wd_cleared_cmd", {4'h0, command}, 8'h00);
    wr(A_CMD, 8'h08);

    // Reset just before a periodic pulse; nothing afterwards until CTRL.
    to_pre_pulse();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    p0 = pulses;
    idle(3 * P);
    check("post_reset_silent", 8'(pulses - p0), 8'd0);

    // Readback, other-address reads, STATUS writes, write+read same cycle.
    wr(A_CMD, 8'h05);
    wr(A_CTL, 8'h01);
    step(1'b0, 1'b0, 1'b1, A_STA, 8'h00);
    idle(1);
    step(1'b0, 1'b0, 1'b1, A_CMD, 8'h00);
    wr(A_STA, 8'hFF);
    step(1'b0, 1'b1, 1'b1, A_CMD, 8'h06);
    step(1'b0, 1'b0, 1'b1, A_STA, 8'h00);
    wr(8'h93, 8'h03);

    // Random bus traffic.
    for (int i = 0; i < 3000; i++) begin
      int pick;
      pick = $urandom_range(0, 5);
      a = (pick < 4) ? 8'(BASE + 8'(pick)) : 8'($urandom);
      d = 8'($urandom);
      if (a == A_CTL && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
